decoder_scan: RTL and testbench



---
 rtl/decoder_scan.sv | 117 +++++++++++
 tb/tb_decoder_scan.sv | 127 ++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// N-to-2^N decoder with registered one-hot output, enable and optional scan mode.
// Scan mode (walking index with programmable dwell) is built only when DECODER_SCAN_EN is defined.
//
// state  | meaning
// IDLE   | disabled, y forced to zero, idx held
// DIRECT | y follows 1<<w with one cycle latency
// SCAN   | index walks through the outputs, each held dwell+1 cycles
module decoder_scan #(
  parameter int N       = 2,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N-1:0]       w,
  input  logic               scan,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  y,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int M = 1 << N;
  localparam logic [M-1:0] ONE = M'(1);

`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIRECT} state_t;
`endif

  state_t         state, state_nxt;
  logic [M-1:0]   y_nxt;
  logic [N-1:0]   idx_nxt;

`ifdef DECODER_SCAN_EN
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               wrap_nxt;
  logic [N-1:0]       idx_inc;

  assign idx_inc = idx + N'(1);

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      y_nxt     = '0;
      cnt_nxt   = '0;
    end else if (scan) begin
      if (state != SCAN) begin
        state_nxt = SCAN;
        idx_nxt   = w;
        y_nxt     = ONE << w;
        cnt_nxt   = dwell;
      end else if (cnt != '0) begin
        cnt_nxt = cnt - DWELL_W'(1);
      end else begin
        // dwell is re-sampled only here, so mid-dwell changes take effect at the next step
        idx_nxt  = idx_inc;
        y_nxt    = ONE << idx_inc;
        cnt_nxt  = dwell;
        wrap_nxt = &idx;
      end
    end else begin
      state_nxt = DIRECT;
      idx_nxt   = w;
      y_nxt     = ONE << w;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end
`else
  logic unused_scan;
  assign unused_scan = ^{scan, dwell};
  assign wrap        = 1'b0;

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    idx_nxt   = idx;
    if (!en) begin
      state_nxt = IDLE;
      y_nxt     = '0;
    end else begin
      state_nxt = DIRECT;
      idx_nxt   = w;
      y_nxt     = ONE << w;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      y     <= y_nxt;
      idx   <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (N=2, DWELL_W=4).
// Expectations follow the DECODER_SCAN_EN setting of the build.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] w;
  logic       scan;
  logic [3:0] dwell;
  logic [3:0] y;
  logic [1:0] idx;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

`ifdef DECODER_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  decoder_scan #(.N(2), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .w     (w),
    .scan  (scan),
    .dwell (dwell),
    .y     (y),
    .idx   (idx),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_y;
  logic       exp_wrap;
  logic [3:0] nd_y  [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic       nd_wr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0; en = 1'b0; w = 2'd0; scan = 1'b0; dwell = 4'd0;
    step();
    check("rst_y", 32'(y), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;

    // direct decode, disabled then enabled
    w = 2'b01; step();
    check("dis_y0", 32'(y), 32'h0);
    w = 2'b10; step();
    check("dis_y1", 32'(y), 32'h0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 2'(i);
      step();
      check($sformatf("dir_y%0d", i), 32'(y), 32'(4'b0001 << i));
      check($sformatf("dir_idx%0d", i), 32'(idx), 32'(i));
    end

    // scan with zero dwell from w=10
    dwell = 4'd0; w = 2'b10; scan = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_y    = SCAN_ON ? nd_y[i] : 4'b0100;
      exp_wrap = SCAN_ON ? nd_wr[i] : 1'b0;
      check($sformatf("nd_y%0d", i), 32'(y), 32'(exp_y));
      check($sformatf("nd_wrap%0d", i), 32'(wrap), 32'(exp_wrap));
    end

    // scan -> direct
    scan = 1'b0; w = 2'b00; step();
    check("sw_dir_y", 32'(y), 32'h1);
    check("sw_dir_idx", 32'(idx), 32'h0);

    // en=0 beats scan=1
    scan = 1'b1; w = 2'b01; step();
    check("pre_dis_y", 32'(y), 32'h2);
    en = 1'b0; step();
    check("dis_pri_y", 32'(y), 32'h0);
    check("dis_pri_idx", 32'(idx), 32'h1);
    check("dis_pri_wrap", 32'(wrap), 32'h0);

    // scan with dwell=2 from w=00
    en = 1'b1; w = 2'b00; dwell = 4'd2;
    for (int k = 0; k < 13; k++) begin
      step();
      exp_y    = SCAN_ON ? 4'(4'b0001 << ((k / 3) % 4)) : 4'b0001;
      exp_wrap = SCAN_ON && (k == 12);
      check($sformatf("dw_y%0d", k), 32'(y), 32'(exp_y));
      check($sformatf("dw_wrap%0d", k), 32'(wrap), 32'(exp_wrap));
    end

    // async reset between edges
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", 32'(y), 32'h0);
    check("arst_idx", 32'(idx), 32'h0);
    check("arst_wrap", 32'(wrap), 32'h0);
    scan = 1'b0; w = 2'b11;
    #1 rst_n = 1'b1;
    step();
    check("post_rst_y", 32'(y), 32'h8);
    check("post_rst_idx", 32'(idx), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
